// File: rtl/uart_sample_rx.sv
// uart_sample_rx
// ---------------------------------------------------------------------------
// Receive side of the UART sample-streaming link. Deserialises 8N1 bytes
// from rx and parses the 5-byte frame "C", "H", '0'+ch, MSB, LSB. Each
// decoded 16-bit signed sample is latched into the output register of its
// channel.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   rx            asynchronous serial input, idle high
//   sample_out0-3 last signed sample decoded for channels 0..3
//   sample_valid  one-cycle pulse when a sample_outN register is written
//   sample_ch     channel of the most recent update (held between pulses)
//   frame_err     one-cycle pulse when a stop bit is sampled low
//   sync_err      one-cycle pulse when the parser discards a partial header
//
// Optional build macro: SAMPLE_RX_TIMEOUT_EN
//   Adds an inter-byte gap counter. If a frame is partially received and
//   the line stays idle for TIMEOUT_BITS bit periods, the parser returns to
//   its hunt state and pulses sync_err once.
// ---------------------------------------------------------------------------
module uart_sample_rx #(
  parameter int CLK_FREQ     = 12_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic signed [15:0] sample_out0,
  output logic signed [15:0] sample_out1,
  output logic signed [15:0] sample_out2,
  output logic signed [15:0] sample_out3,
  output logic               sample_valid,
  output logic [1:0]         sample_ch,
  output logic               frame_err,
  output logic               sync_err
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  localparam logic [7:0] CHAR_C  = 8'h43;
  localparam logic [7:0] CHAR_H  = 8'h48;
  localparam logic [7:0] CHAR_0  = 8'h30;
  localparam logic [7:0] CHAR_3  = 8'h33;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  typedef enum logic [2:0] {
    P_C,
    P_H,
    P_ID,
    P_MSB,
    P_LSB
  } p_state_t;

  // Two-flop synchroniser; everything downstream uses rxs_q only.
  logic rx_meta_q;
  logic rxs_q;

  // Bit-level receiver
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_stb_q, byte_stb_d;
  logic             frame_err_q, frame_err_d;

  // Frame parser
  p_state_t           p_state_q, p_state_d;
  logic [1:0]         ch_q, ch_d;
  logic [7:0]         msb_q, msb_d;
  logic signed [15:0] sample_q [4];
  logic signed [15:0] sample_d [4];
  logic [1:0]         sample_ch_q, sample_ch_d;
  logic               sample_valid_q, sample_valid_d;
  logic               sync_err_q, sync_err_d;

  logic               timeout_hit;

`ifdef SAMPLE_RX_TIMEOUT_EN
  localparam int GAP_LIMIT = TIMEOUT_BITS * DIV;
  localparam int GAP_W     = $clog2(GAP_LIMIT + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_LIMIT);

  logic [GAP_W-1:0] gap_q, gap_d;

  // Saturates at the limit so the timeout cannot wrap and fire again;
  // the parser only leaves P_C on a byte strobe, which clears the gap.
  always_comb begin
    gap_d = gap_q;
    if (byte_stb_q) begin
      gap_d = '0;
    end else if (rx_state_q == RX_IDLE && gap_q != GAP_MAX) begin
      gap_d = gap_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end

  assign timeout_hit = (gap_q == GAP_MAX) && (p_state_q != P_C);
`else
  assign timeout_hit = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Receiver next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    rx_state_d  = rx_state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_stb_d  = 1'b0;
    frame_err_d = 1'b0;

    unique case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rxs_q) begin
          rx_state_d = RX_START;
        end
      end

      // Re-check the line half a bit in: a high here means the falling
      // edge was a glitch, so drop back silently.
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          rx_state_d = rxs_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rxs_q) begin
            byte_stb_d = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            rx_state_d  = RX_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Line held low past the stop bit: wait for it to return high so the
      // low level is not mistaken for a new start bit.
      RX_BREAK: begin
        cnt_d = '0;
        if (rxs_q) begin
          rx_state_d = RX_IDLE;
        end
      end

      default: begin
        rx_state_d = RX_IDLE;
        cnt_d      = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Parser next-state logic. shift_q still holds the completed byte in the
  // cycle byte_stb_q is high, because the receiver is back in IDLE.
  // -------------------------------------------------------------------------
  always_comb begin
    p_state_d      = p_state_q;
    ch_d           = ch_q;
    msb_d          = msb_q;
    sample_d       = sample_q;
    sample_ch_d    = sample_ch_q;
    sample_valid_d = 1'b0;
    sync_err_d     = 1'b0;

    if (frame_err_q) begin
      p_state_d = P_C;
    end else if (byte_stb_q) begin
      unique case (p_state_q)
        P_C: begin
          if (shift_q == CHAR_C) begin
            p_state_d = P_H;
          end
        end

        P_H: begin
          if (shift_q == CHAR_H) begin
            p_state_d = P_ID;
          end else if (shift_q == CHAR_C) begin
            p_state_d = P_H;
          end else begin
            p_state_d  = P_C;
            sync_err_d = 1'b1;
          end
        end

        P_ID: begin
          if (shift_q >= CHAR_0 && shift_q <= CHAR_3) begin
            ch_d      = shift_q[1:0];
            p_state_d = P_MSB;
          end else if (shift_q == CHAR_C) begin
            p_state_d  = P_H;
            sync_err_d = 1'b1;
          end else begin
            p_state_d  = P_C;
            sync_err_d = 1'b1;
          end
        end

        // Payload bytes are taken as-is; 0x43 is a legal data value here.
        P_MSB: begin
          msb_d     = shift_q;
          p_state_d = P_LSB;
        end

        P_LSB: begin
          sample_d[ch_q] = {msb_q, shift_q};
          sample_ch_d    = ch_q;
          sample_valid_d = 1'b1;
          p_state_d      = P_C;
        end

        default: begin
          p_state_d = P_C;
        end
      endcase
    end else if (timeout_hit) begin
      p_state_d  = P_C;
      sync_err_d = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q      <= 1'b1;
      rxs_q          <= 1'b1;
      rx_state_q     <= RX_IDLE;
      cnt_q          <= '0;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      byte_stb_q     <= 1'b0;
      frame_err_q    <= 1'b0;
      p_state_q      <= P_C;
      ch_q           <= '0;
      msb_q          <= '0;
      sample_ch_q    <= '0;
      sample_valid_q <= 1'b0;
      sync_err_q     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        sample_q[i] <= '0;
      end
    end else begin
      rx_meta_q      <= rx;
      rxs_q          <= rx_meta_q;
      rx_state_q     <= rx_state_d;
      cnt_q          <= cnt_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      byte_stb_q     <= byte_stb_d;
      frame_err_q    <= frame_err_d;
      p_state_q      <= p_state_d;
      ch_q           <= ch_d;
      msb_q          <= msb_d;
      sample_ch_q    <= sample_ch_d;
      sample_valid_q <= sample_valid_d;
      sync_err_q     <= sync_err_d;
      for (int i = 0; i < 4; i++) begin
        sample_q[i] <= sample_d[i];
      end
    end
  end

  assign sample_out0  = sample_q[0];
  assign sample_out1  = sample_q[1];
  assign sample_out2  = sample_q[2];
  assign sample_out3  = sample_q[3];
  assign sample_ch    = sample_ch_q;
  assign sample_valid = sample_valid_q;
  assign frame_err    = frame_err_q;
  assign sync_err     = sync_err_q;

endmodule

// File: tb/tb_uart_sample_rx.sv
// tb_uart_sample_rx
// Directed bench for uart_sample_rx at the default parameters (DIV = 104).
// Serial bytes are driven one bit period at a time; outputs are compared
// 1 time unit after a rising clock edge, and pulse outputs are counted on
// the falling edge so each step can check how many pulses it produced.
module tb_uart_sample_rx;

  localparam int DIV = 12_000_000 / 115200;

  logic               clk;
  logic               rst;
  logic               rx;
  logic signed [15:0] sample_out0;
  logic signed [15:0] sample_out1;
  logic signed [15:0] sample_out2;
  logic signed [15:0] sample_out3;
  logic               sample_valid;
  logic [1:0]         sample_ch;
  logic               frame_err;
  logic               sync_err;

  int n_cmp;
  int n_err;

  int cyc;
  int n_valid;
  int n_frame;
  int n_sync;
  int last_valid_cyc;
  int prev_valid_cyc;

  int base_valid;
  int base_frame;
  int base_sync;

  uart_sample_rx dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .sample_out0  (sample_out0),
    .sample_out1  (sample_out1),
    .sample_out2  (sample_out2),
    .sample_out3  (sample_out3),
    .sample_valid (sample_valid),
    .sample_ch    (sample_ch),
    .frame_err    (frame_err),
    .sync_err     (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (sample_valid) begin
      n_valid        <= n_valid + 1;
      prev_valid_cyc <= last_valid_cyc;
      last_valid_cyc <= cyc;
    end
    if (frame_err) n_frame <= n_frame + 1;
    if (sync_err)  n_sync  <= n_sync + 1;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_low);
    rx = 1'b0;
    wait_cycles(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(DIV);
    end
    rx = stop_low ? 1'b0 : 1'b1;
    wait_cycles(DIV);
  endtask

  task automatic send_frame(input logic [1:0] ch, input logic [7:0] msb,
                            input logic [7:0] lsb);
    send_byte(8'h43, 1'b0);
    send_byte(8'h48, 1'b0);
    send_byte(8'h30 + {6'd0, ch}, 1'b0);
    send_byte(msb, 1'b0);
    send_byte(lsb, 1'b0);
  endtask

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-22s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic mark();
    base_valid = n_valid;
    base_frame = n_frame;
    base_sync  = n_sync;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    n_valid = 0;
    n_frame = 0;
    n_sync = 0;
    last_valid_cyc = 0;
    prev_valid_cyc = 0;
    rst = 1'b1;
    rx  = 1'b1;

    // Reset state
    wait_cycles(5);
    check("rst_out0", sample_out0, 16'h0000);
    check("rst_out1", sample_out1, 16'h0000);
    check("rst_out2", sample_out2, 16'h0000);
    check("rst_out3", sample_out3, 16'h0000);
    check("rst_ch", {14'd0, sample_ch}, 16'd0);
    check("rst_pulses", {13'd0, sample_valid, frame_err, sync_err}, 16'd0);
    rst = 1'b0;
    wait_cycles(2 * DIV);

    // Basic frame to channel 2
    mark();
    send_frame(2'd2, 8'h12, 8'h34);
    check("f1_out2", sample_out2, 16'h1234);
    check("f1_ch", {14'd0, sample_ch}, 16'd2);
    check("f1_out0", sample_out0, 16'h0000);
    check("f1_out1", sample_out1, 16'h0000);
    check("f1_out3", sample_out3, 16'h0000);
    check("f1_valid_cnt", 16'(n_valid - base_valid), 16'd1);
    check("f1_err_cnt", 16'(n_frame - base_frame + n_sync - base_sync), 16'd0);

    // Back-to-back extremes on channels 0 and 3
    mark();
    send_frame(2'd0, 8'h80, 8'h00);
    send_frame(2'd3, 8'h7F, 8'hFF);
    check("bb_out0", sample_out0, 16'h8000);
    check("bb_out3", sample_out3, 16'h7FFF);
    check("bb_ch", {14'd0, sample_ch}, 16'd3);
    check("bb_valid_cnt", 16'(n_valid - base_valid), 16'd2);
    check("bb_spacing", 16'(last_valid_cyc - prev_valid_cyc), 16'(50 * DIV));
    check("bb_out2_hold", sample_out2, 16'h1234);

    // Bad channel id, then frame with 0x43 as payload MSB
    mark();
    send_byte(8'h43, 1'b0);
    send_byte(8'h48, 1'b0);
    send_byte(8'h37, 1'b0);
    check("id7_sync_cnt", 16'(n_sync - base_sync), 16'd1);
    send_frame(2'd1, 8'h43, 8'hCD);
    check("id7_out1", sample_out1, 16'h43CD);
    check("id7_valid_cnt", 16'(n_valid - base_valid), 16'd1);
    check("id7_sync_total", 16'(n_sync - base_sync), 16'd1);

    // Stop bit held low during the MSB byte
    mark();
    send_byte(8'h43, 1'b0);
    send_byte(8'h48, 1'b0);
    send_byte(8'h32, 1'b0);
    send_byte(8'h55, 1'b1);
    rx = 1'b1;
    wait_cycles(2 * DIV);
    check("fe_frame_cnt", 16'(n_frame - base_frame), 16'd1);
    check("fe_valid_cnt", 16'(n_valid - base_valid), 16'd0);
    check("fe_out2_hold", sample_out2, 16'h1234);
    send_frame(2'd2, 8'h00, 8'h05);
    check("fe_out2_new", sample_out2, 16'h0005);
    check("fe_sync_cnt", 16'(n_sync - base_sync), 16'd0);

    // 30-cycle glitch between header bytes must not produce a byte
    mark();
    send_byte(8'h43, 1'b0);
    rx = 1'b0;
    wait_cycles(30);
    rx = 1'b1;
    wait_cycles(2 * DIV);
    send_byte(8'h48, 1'b0);
    send_byte(8'h31, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    check("gl_out1", sample_out1, 16'h1122);
    check("gl_err_cnt", 16'(n_frame - base_frame + n_sync - base_sync), 16'd0);
    check("gl_valid_cnt", 16'(n_valid - base_valid), 16'd1);

    // Reset in the middle of the MSB byte
    mark();
    send_byte(8'h43, 1'b0);
    send_byte(8'h48, 1'b0);
    send_byte(8'h31, 1'b0);
    rx = 1'b0;
    wait_cycles(3 * DIV);
    rst = 1'b1;
    rx  = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(1);
    check("mr_out0", sample_out0, 16'h0000);
    check("mr_out1", sample_out1, 16'h0000);
    check("mr_out2", sample_out2, 16'h0000);
    check("mr_out3", sample_out3, 16'h0000);
    check("mr_ch", {14'd0, sample_ch}, 16'd0);
    wait_cycles(2 * DIV);
    check("mr_valid_cnt", 16'(n_valid - base_valid), 16'd0);
    send_frame(2'd1, 8'hAB, 8'hCD);
    check("mr_out1_new", sample_out1, 16'hABCD);
    check("mr_ch_new", {14'd0, sample_ch}, 16'd1);
    check("mr_out2_hold", sample_out2, 16'h0000);
    check("mr_valid_cnt2", 16'(n_valid - base_valid), 16'd1);

`ifdef SAMPLE_RX_TIMEOUT_EN
    // Idle gap after the id byte abandons the frame
    mark();
    send_byte(8'h43, 1'b0);
    send_byte(8'h48, 1'b0);
    send_byte(8'h31, 1'b0);
    wait_cycles(25 * DIV);
    check("to_sync_cnt", 16'(n_sync - base_sync), 16'd1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h07, 1'b0);
    wait_cycles(DIV);
    check("to_valid_cnt", 16'(n_valid - base_valid), 16'd0);
    check("to_out1_hold", sample_out1, 16'hABCD);
    check("to_sync_total", 16'(n_sync - base_sync), 16'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
